uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 15 +
 rtl/uart_rx.sv | 95 +++++++++
 tb/tb_uart_rx.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial input, tick enable and received-byte handshake for uart_rx.
interface uart_rx_if;
  logic       tick16;
  logic       rxd;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  modport master (input tick16, rxd, rx_ack,
                  output rx_data, rx_ready, frame_err, parity_err, overrun);
  modport slave  (output tick16, rxd, rx_ack,
                  input rx_data, rx_ready, frame_err, parity_err, overrun);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled 8-bit serial receiver with ready/ack handoff and overrun flag.
// Define UART_RX_PARITY_EN to receive an even parity bit between data and stop.
module uart_rx (
  input logic      clk,
  input logic      rst,
  uart_rx_if.master bus
);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  localparam state_t AFTER_DATA = PARITY;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t     state, state_n;
  logic [1:0] sync;
  logic       rxs;
  logic [3:0] cnt;
  logic [2:0] idx;
  logic [7:0] sh;
  logic [7:0] data;
  logic       ready, ferr, ovr, perr;
  logic       sample, done;
  assign rxs    = sync[1];
  assign sample = bus.tick16 && cnt == 4'd15;
  assign done   = sample && state == STOP;
  always_comb begin
    state_n = state;
    if (bus.tick16)
      case (state)
        IDLE:    state_n = rxs ? IDLE : START;
        START:   state_n = cnt != 4'd7 ? START : rxs ? IDLE : DATA;
        DATA:    state_n = cnt == 4'd15 && idx == 3'd7 ? AFTER_DATA : DATA;
`ifdef UART_RX_PARITY_EN
        PARITY:  state_n = cnt == 4'd15 ? STOP : PARITY;
`endif
        STOP:    state_n = cnt != 4'd15 ? STOP : rxs ? IDLE : BREAK;
        BREAK:   state_n = rxs ? IDLE : BREAK;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sync  <= 2'b11;
    end else begin
      state <= state_n;
      sync  <= {sync[0], bus.rxd};
    end
  end
`ifdef UART_RX_PARITY_EN
  logic par;
  always_ff @(posedge clk or negedge rst)
    if (!rst) par <= 1'b0;
    else if (sample && state == PARITY) par <= rxs;
`endif
  // counter restarts on every state change; within DATA it simply wraps 15->0 per bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= 4'd0;
      idx   <= 3'd0;
      sh    <= 8'h00;
      data  <= 8'h00;
      ready <= 1'b0;
      ferr  <= 1'b0;
      perr  <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      if (bus.tick16)
        cnt <= (state_n != state || state == IDLE || state == BREAK) ? 4'd0 : cnt + 4'd1;
      if (state == START) idx <= 3'd0;
      else if (sample && state == DATA) idx <= idx + 3'd1;
      if (sample && state == DATA) sh <= {rxs, sh[7:1]};
      if (done) begin
        data  <= sh;
        ready <= 1'b1;
        ferr  <= ~rxs;
`ifdef UART_RX_PARITY_EN
        perr  <= ^{sh, par};
`else
        perr  <= 1'b0;
`endif
        ovr   <= ready & ~bus.rx_ack;
      end else if (bus.rx_ack) begin
        ready <= 1'b0;
        ovr   <= 1'b0;
      end
    end
  end
  assign bus.rx_data    = data;
  assign bus.rx_ready   = ready;
  assign bus.frame_err  = ferr;
  assign bus.parity_err = perr;
  assign bus.overrun    = ovr;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: random-jitter serial frames checked against a frame-level model of the receiver outputs.
module tb_uart_rx;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  uart_rx_if bus();
  uart_rx dut (.clk(clk), .rst(rst), .bus(bus));
  int vectors = 0;
  int errors  = 0;
  logic [7:0]  m_data;
  logic        m_ready, m_ferr, m_perr, m_ovr;
  logic [11:0] pre_obs, pre_exp, post_obs, post_exp;

  function automatic logic [11:0] obs();
    return {bus.rx_data, bus.rx_ready, bus.frame_err, bus.parity_err, bus.overrun};
  endfunction

  function automatic logic [11:0] model();
    return {m_data, m_ready, m_ferr, m_perr, m_ovr};
  endfunction

  task automatic model_reset();
    m_data = 8'h00; m_ready = 0; m_ferr = 0; m_perr = 0; m_ovr = 0;
  endtask

  // one oversample tick with an irregular gap so only the pulse count matters
  task automatic tick(input logic b, input logic a);
    bus.rxd = b;
    repeat ($urandom_range(2, 4)) @(negedge clk);
    bus.tick16 = 1'b1;
    bus.rx_ack = a;
    @(negedge clk);
    bus.tick16 = 1'b0;
    bus.rx_ack = 1'b0;
  endtask

  task automatic ticks(input logic b, input int n);
    for (int i = 0; i < n; i++) tick(b, 1'b0);
  endtask

  task automatic do_ack();
    bus.rx_ack = 1'b1;
    @(negedge clk);
    bus.rx_ack = 1'b0;
    m_ready = 0; m_ovr = 0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stopb, input logic parb, input logic ack);
    ticks(1'b0, 16);
    for (int b = 0; b < 8; b++) ticks(d[b], 16);
`ifdef UART_RX_PARITY_EN
    ticks(parb, 16);
`endif
    ticks(stopb, 8);
    bus.rxd = stopb;
    repeat ($urandom_range(2, 4)) @(negedge clk);
    pre_obs = obs();
    pre_exp = model();
    bus.tick16 = 1'b1;
    bus.rx_ack = ack;
    @(negedge clk);
    bus.tick16 = 1'b0;
    bus.rx_ack = 1'b0;
    m_ovr   = (m_ready && !ack) ? 1'b1 : (ack ? 1'b0 : m_ovr);
    m_ready = 1'b1;
    m_data  = d;
    m_ferr  = !stopb;
`ifdef UART_RX_PARITY_EN
    m_perr  = ^d ^ parb;
`else
    m_perr  = 1'b0;
`endif
    post_obs = obs();
    post_exp = model();
    ticks(stopb, 7);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.rxd = 1'b1; bus.tick16 = 1'b0; bus.rx_ack = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if (obs() !== 12'h000) begin errors++; $display("FAIL reset got=%h want=%h", obs(), 12'h000); end
    rst = 1'b1;
    ticks(1'b1, 4);
    vectors++;
    if (obs() !== 12'h000) begin errors++; $display("FAIL reset_idle got=%h want=%h", obs(), 12'h000); end
  endtask

  task automatic test_basic();
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (pre_obs !== 12'h000) begin errors++; $display("FAIL basic_pre got=%h want=%h", pre_obs, 12'h000); end
    vectors++;
    if (post_obs !== {8'hA5, 4'b1000}) begin errors++; $display("FAIL basic_a5 got=%h want=%h", post_obs, {8'hA5, 4'b1000}); end
    ticks(1'b1, 3);
    do_ack();
    vectors++;
    if (obs() !== {8'hA5, 4'b0000}) begin errors++; $display("FAIL basic_ack got=%h want=%h", obs(), {8'hA5, 4'b0000}); end
  endtask

  task automatic test_glitch();
    ticks(1'b0, 5);
    ticks(1'b1, 20);
    vectors++;
    if (obs() !== {8'hA5, 4'b0000}) begin errors++; $display("FAIL glitch got=%h want=%h", obs(), {8'hA5, 4'b0000}); end
    send_frame(8'h96, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (post_obs !== {8'h96, 4'b1000}) begin errors++; $display("FAIL glitch_next got=%h want=%h", post_obs, {8'h96, 4'b1000}); end
    ticks(1'b1, 2);
    do_ack();
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (post_obs !== {8'h3C, 4'b1100}) begin errors++; $display("FAIL ferr_3c got=%h want=%h", post_obs, {8'h3C, 4'b1100}); end
    ticks(1'b0, 40);
    vectors++;
    if (obs() !== {8'h3C, 4'b1100}) begin errors++; $display("FAIL ferr_hold got=%h want=%h", obs(), {8'h3C, 4'b1100}); end
    ticks(1'b1, 4);
    do_ack();
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (post_obs !== {8'h55, 4'b1000}) begin errors++; $display("FAIL ferr_55 got=%h want=%h", post_obs, {8'h55, 4'b1000}); end
    ticks(1'b1, 2);
    do_ack();
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (post_obs !== {8'h22, 4'b1001}) begin errors++; $display("FAIL overrun got=%h want=%h", post_obs, {8'h22, 4'b1001}); end
    ticks(1'b1, 2);
    do_ack();
    vectors++;
    if (obs() !== {8'h22, 4'b0000}) begin errors++; $display("FAIL overrun_ack got=%h want=%h", obs(), {8'h22, 4'b0000}); end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b1);
    vectors++;
    if (post_obs !== {8'hC3, 4'b1000}) begin errors++; $display("FAIL ack_collide got=%h want=%h", post_obs, {8'hC3, 4'b1000}); end
    ticks(1'b1, 2);
    do_ack();
  endtask

  task automatic test_reset_midframe();
    ticks(1'b0, 16);
    ticks(1'b1, 64);
    rst = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (obs() !== 12'h000) begin errors++; $display("FAIL rst_async got=%h want=%h", obs(), 12'h000); end
    bus.rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    ticks(1'b1, 4);
    send_frame(8'h0F, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (post_obs !== {8'h0F, 4'b1000}) begin errors++; $display("FAIL rst_0f got=%h want=%h", post_obs, {8'h0F, 4'b1000}); end
    ticks(1'b1, 2);
    do_ack();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (post_obs !== {8'h07, 4'b1010}) begin errors++; $display("FAIL parity_bad got=%h want=%h", post_obs, {8'h07, 4'b1010}); end
    ticks(1'b1, 2);
    do_ack();
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    vectors++;
    if (post_obs !== {8'h07, 4'b1000}) begin errors++; $display("FAIL parity_ok got=%h want=%h", post_obs, {8'h07, 4'b1000}); end
    ticks(1'b1, 2);
    do_ack();
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      logic stopb;
      d = 8'($urandom);
      stopb = $urandom_range(0, 5) != 0;
      send_frame(d, stopb, 1'($urandom), 1'($urandom));
      vectors++;
      if (pre_obs !== pre_exp) begin errors++; $display("FAIL rand_pre%0d got=%h want=%h", n, pre_obs, pre_exp); end
      vectors++;
      if (post_obs !== post_exp) begin errors++; $display("FAIL rand_post%0d got=%h want=%h", n, post_obs, post_exp); end
      if (!stopb) ticks(1'b0, $urandom_range(0, 20));
      ticks(1'b1, $urandom_range(stopb ? 0 : 1, 3));
      if ($urandom_range(0, 2) == 0) begin
        do_ack();
        vectors++;
        if (obs() !== model()) begin errors++; $display("FAIL rand_ack%0d got=%h want=%h", n, obs(), model()); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
